// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and constants for the instruction-RAM arbiter
package imem_arb_pkg;

  typedef enum logic [1:0] {IDLE, CPU_RSP, WB_RSP} state_t;
  typedef enum logic {GNT_CPU, GNT_WB} grant_t;

  localparam int          DEF_ADDR_W = 6;
  localparam int          DATA_W     = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  // Bits above the word index must be zero; the byte offset is don't-care.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, Wishbone and SRAM signals of the instruction-RAM arbiter
interface imem_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_inst;
  logic              cpu_valid;

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [31:0]       wb_adr_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [3:0]        wb_sel_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, mem_rdata,
    output cpu_inst, cpu_valid, wb_dat_o, wb_ack_o, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, mem_rdata,
    input  cpu_inst, cpu_valid, wb_dat_o, wb_ack_o, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// rtl/imem_arbiter_rr_arb2.sv - two-way round-robin arbiter; bit 0 is the CPU, bit 1 is Wishbone
module rr_arb2
  import imem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  grant_t last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_WB) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Resetting to WB lets the CPU win the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= GNT_WB;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt[1] ? GNT_WB : GNT_CPU;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - shares one synchronous-read instruction RAM between fetch and a Wishbone slave
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);

  state_t      state, state_nxt;
  logic [1:0]  req, gnt;
  logic        issue, issue_range;
  logic        in_range_q, we_q;
  logic [31:0] cpu_inst_q, wb_dat_q, cpu_rsp, wb_rsp;
  logic        cpu_valid, wb_ack;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;

  // Arbitration only happens in IDLE and never while reset is asserted.
  assign req   = {bus.wb_cyc_i & bus.wb_stb_i, bus.cpu_req} & {2{(state == IDLE) && rst_n}};
  assign issue = |gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (issue),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    issue_range = 1'b0;
    case (state)
      IDLE: begin
        if (gnt[0]) begin
          mem_en      = 1'b1;
          mem_addr    = bus.cpu_addr[ADDR_W+1:2];
          issue_range = addr_in_range(bus.cpu_addr, ADDR_W);
          state_nxt   = CPU_RSP;
        end else if (gnt[1]) begin
          mem_en      = 1'b1;
          mem_addr    = bus.wb_adr_i[ADDR_W+1:2];
          issue_range = addr_in_range(bus.wb_adr_i, ADDR_W);
          if (bus.wb_we_i && issue_range) begin
            mem_we    = bus.wb_sel_i;
            mem_wdata = bus.wb_dat_i;
          end
          state_nxt   = WB_RSP;
        end
      end
      CPU_RSP: state_nxt = IDLE;
      WB_RSP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_rsp   = in_range_q ? bus.mem_rdata : NOP_INST;
  assign wb_rsp    = in_range_q ? bus.mem_rdata : 32'd0;
  assign cpu_valid = (state == CPU_RSP) && rst_n;
  assign wb_ack    = (state == WB_RSP) && rst_n && bus.wb_cyc_i && bus.wb_stb_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_range_q <= 1'b0;
      we_q       <= 1'b0;
      cpu_inst_q <= 32'd0;
      wb_dat_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        in_range_q <= issue_range;
        we_q       <= gnt[1] & bus.wb_we_i;
      end
      if (cpu_valid) cpu_inst_q <= cpu_rsp;
      if (wb_ack && !we_q) wb_dat_q <= wb_rsp;
    end
  end

  // Response data is live in the response cycle and held afterwards.
  assign bus.cpu_inst  = cpu_valid ? cpu_rsp : cpu_inst_q;
  assign bus.cpu_valid = cpu_valid;
  assign bus.wb_dat_o  = (wb_ack && !we_q) ? wb_rsp : wb_dat_q;
  assign bus.wb_ack_o  = wb_ack;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter with a behavioural SRAM
module tb_imem_arbiter;
  import imem_arb_pkg::*;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW)) bus ();

  imem_arbiter #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cpu_req  = 1'b0; bus.cpu_addr = 32'd0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'd0; bus.wb_dat_i = 32'd0; bus.wb_sel_i = 4'b0000;
  endtask

  task automatic wb_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    mid();
    tests++; if (bus.cpu_valid !== 1'b0) begin fails++; $display("FAIL reset_cpu_valid got %0b want 0", bus.cpu_valid); end
    tests++; if (bus.wb_ack_o !== 1'b0) begin fails++; $display("FAIL reset_wb_ack got %0b want 0", bus.wb_ack_o); end
    tests++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 4'b0) begin fails++; $display("FAIL reset_mem got en=%0b we=%b want 0/0000", bus.mem_en, bus.mem_we); end
    tests++; if (bus.cpu_inst !== 32'd0 || bus.wb_dat_o !== 32'd0) begin fails++; $display("FAIL reset_data got inst=%h dat=%h want 0/0", bus.cpu_inst, bus.wb_dat_o); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cpu_fetch();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8;
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd2 || bus.mem_we !== 4'b0) begin fails++; $display("FAIL fetch_issue got en=%0b addr=%0d we=%b want 1/2/0000", bus.mem_en, bus.mem_addr, bus.mem_we); end
    tests++; if (bus.cpu_valid !== 1'b0) begin fails++; $display("FAIL fetch_early_valid got %0b want 0", bus.cpu_valid); end
    step();
    bus.cpu_req = 1'b0;
    mid();
    tests++; if (bus.cpu_valid !== 1'b1 || bus.cpu_inst !== 32'h0050_0093) begin fails++; $display("FAIL fetch_rsp got valid=%0b inst=%h want 1/00500093", bus.cpu_valid, bus.cpu_inst); end
    tests++; if (bus.mem_en !== 1'b0) begin fails++; $display("FAIL fetch_rsp_mem_en got %0b want 0", bus.mem_en); end
    step();
    mid();
    tests++; if (bus.cpu_valid !== 1'b0 || bus.cpu_inst !== 32'h0050_0093) begin fails++; $display("FAIL fetch_hold got valid=%0b inst=%h want 0/00500093", bus.cpu_valid, bus.cpu_inst); end
    step();
  endtask

  task automatic test_wb_write_read();
    wb_drive(1'b1, 32'hC, 32'hDEAD_BEEF, 4'b0011);
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'b0011 || bus.mem_addr !== 6'd3 || bus.mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wbw_issue got en=%0b we=%b addr=%0d wdata=%h want 1/0011/3/deadbeef", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    tests++; if (bus.wb_ack_o !== 1'b0) begin fails++; $display("FAIL wbw_early_ack got %0b want 0", bus.wb_ack_o); end
    step();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b1) begin fails++; $display("FAIL wbw_ack got %0b want 1", bus.wb_ack_o); end
    step();
    idle_inputs();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b0) begin fails++; $display("FAIL wbw_ack_pulse got %0b want 0", bus.wb_ack_o); end
    step();
    wb_drive(1'b0, 32'hC, 32'd0, 4'b1111);
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'b0 || bus.mem_addr !== 6'd3) begin fails++; $display("FAIL wbr_issue got en=%0b we=%b addr=%0d want 1/0000/3", bus.mem_en, bus.mem_we, bus.mem_addr); end
    step();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h1122_BEEF) begin fails++; $display("FAIL wbr_rsp got ack=%0b dat=%h want 1/1122beef", bus.wb_ack_o, bus.wb_dat_o); end
    step();
    idle_inputs();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h1122_BEEF) begin fails++; $display("FAIL wbr_hold got ack=%0b dat=%h want 0/1122beef", bus.wb_ack_o, bus.wb_dat_o); end
    step();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8;
    wb_drive(1'b0, 32'hC, 32'd0, 4'b1111);
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd2) begin fails++; $display("FAIL rr_tie1 got en=%0b addr=%0d want 1/2 (cpu)", bus.mem_en, bus.mem_addr); end
    step();
    mid();
    tests++; if (bus.cpu_valid !== 1'b1 || bus.wb_ack_o !== 1'b0) begin fails++; $display("FAIL rr_rsp1 got valid=%0b ack=%0b want 1/0", bus.cpu_valid, bus.wb_ack_o); end
    step();
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd3 || bus.cpu_valid !== 1'b0) begin fails++; $display("FAIL rr_tie2 got en=%0b addr=%0d valid=%0b want 1/3/0 (wb)", bus.mem_en, bus.mem_addr, bus.cpu_valid); end
    step();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'h1122_BEEF || bus.cpu_valid !== 1'b0) begin fails++; $display("FAIL rr_rsp2 got ack=%0b dat=%h valid=%0b want 1/1122beef/0", bus.wb_ack_o, bus.wb_dat_o, bus.cpu_valid); end
    step();
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd2) begin fails++; $display("FAIL rr_tie3 got en=%0b addr=%0d want 1/2 (cpu)", bus.mem_en, bus.mem_addr); end
    step();
    idle_inputs();
    mid();
    tests++; if (bus.cpu_valid !== 1'b1 || bus.wb_ack_o !== 1'b0) begin fails++; $display("FAIL rr_rsp3 got valid=%0b ack=%0b want 1/0", bus.cpu_valid, bus.wb_ack_o); end
    step();
  endtask

  task automatic test_out_of_range();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h100;
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd0) begin fails++; $display("FAIL oor_fetch_issue got en=%0b addr=%0d want 1/0", bus.mem_en, bus.mem_addr); end
    step();
    bus.cpu_req = 1'b0;
    mid();
    tests++; if (bus.cpu_valid !== 1'b1 || bus.cpu_inst !== NOP_INST) begin fails++; $display("FAIL oor_fetch got valid=%0b inst=%h want 1/00000013", bus.cpu_valid, bus.cpu_inst); end
    step();
    wb_drive(1'b1, 32'h100, 32'hCAFE_F00D, 4'b1111);
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 4'b0) begin fails++; $display("FAIL oor_write_issue got en=%0b we=%b want 1/0000", bus.mem_en, bus.mem_we); end
    step();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b1) begin fails++; $display("FAIL oor_write_ack got %0b want 1", bus.wb_ack_o); end
    step();
    idle_inputs();
    mid();
    tests++; if (ram[0] !== 32'hA5A5_0000) begin fails++; $display("FAIL oor_write_ram got %h want a5a50000", ram[0]); end
    step();
    wb_drive(1'b0, 32'h100, 32'd0, 4'b1111);
    step();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b1 || bus.wb_dat_o !== 32'd0) begin fails++; $display("FAIL oor_read got ack=%0b dat=%h want 1/0", bus.wb_ack_o, bus.wb_dat_o); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_wb_abort();
    wb_drive(1'b0, 32'h8, 32'd0, 4'b1111);
    mid();
    tests++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd2) begin fails++; $display("FAIL abort_issue got en=%0b addr=%0d want 1/2", bus.mem_en, bus.mem_addr); end
    step();
    idle_inputs();
    mid();
    tests++; if (bus.wb_ack_o !== 1'b0 || dut.state !== WB_RSP) begin fails++; $display("FAIL abort_rsp got ack=%0b state=%0d want 0/WB_RSP", bus.wb_ack_o, dut.state); end
    step();
    mid();
    tests++; if (dut.state !== IDLE || bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'd0) begin fails++; $display("FAIL abort_idle got state=%0d ack=%0b dat=%h want IDLE/0/0", dut.state, bus.wb_ack_o, bus.wb_dat_o); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8;
    mid();
    tests++; if (bus.mem_en !== 1'b1) begin fails++; $display("FAIL rstmid_issue got %0b want 1", bus.mem_en); end
    step();
    bus.cpu_req = 1'b0;
    rst_n = 1'b0;
    mid();
    tests++; if (bus.cpu_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %0b want 0", bus.cpu_valid); end
    step();
    rst_n = 1'b1;
    mid();
    tests++; if (dut.state !== IDLE || bus.cpu_valid !== 1'b0 || bus.cpu_inst !== 32'd0 || bus.wb_dat_o !== 32'd0 || bus.mem_en !== 1'b0) begin fails++; $display("FAIL rstmid_after got state=%0d valid=%0b inst=%h dat=%h en=%0b want IDLE/0/0/0/0", dut.state, bus.cpu_valid, bus.cpu_inst, bus.wb_dat_o, bus.mem_en); end
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA5A5_0000 | i;
    ram[2] = 32'h0050_0093;
    ram[3] = 32'h1122_3344;
    bus.mem_rdata = 32'd0;
    idle_inputs();
    test_reset();
    test_cpu_fetch();
    test_wb_write_read();
    test_round_robin();
    test_out_of_range();
    test_wb_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
